// File: rtl/clk_tick_stepper_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_tick_stepper_if
//  Purpose  : Control and status bundle between the tick stepper and its user.
//  Revision : 1.0  initial release
// ============================================================================
interface clk_tick_stepper_if #(
    parameter int CNT_W = 32
);
    logic             clk_div_in;
    logic             run;
    logic             step;
    logic             halt;
    logic             core_en;
    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       state;
    logic             stalled;

    modport master (
        output clk_div_in, run, step, halt,
        input  core_en, tick_cnt, state, stalled
    );

    modport slave (
        input  clk_div_in, run, step, halt,
        output core_en, tick_cnt, state, stalled
    );
endinterface
`default_nettype wire

// File: rtl/clk_tick_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : clk_tick_stepper
//  Purpose  : Turns rising edges of the divided clock into one-cycle core
//             enables, gated by a run/step/halt FSM, with tick count and stall
//             watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module clk_tick_stepper #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 12500000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    clk_tick_stepper_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_ARMED = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] c_wdog_max  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_step_d;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_core_en;
    logic                   w_core_en_nxt;
    logic [CNT_W-1:0]       r_tick_cnt;
    logic [CNT_W-1:0]       r_wdog;
    logic                   r_stalled;
    logic                   w_rise;
    logic                   w_step_rise;
    logic                   w_active;

    assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_step_rise = bus.step & ~r_step_d;
    assign w_active    = (r_state == S_RUN) || (r_state == S_ARMED);

    // clk_div_in is asynchronous; only the last stage is ever used as data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_prev   <= 1'b0;
            r_step_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.clk_div_in};
            r_prev   <= r_sync[SYNC_STAGES-1];
            r_step_d <= bus.step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_core_en_nxt = w_rise & ~bus.halt & w_active;
        case (r_state)
            S_IDLE: begin
                if (bus.halt)        w_state_nxt = S_IDLE;
                else if (w_step_rise) w_state_nxt = S_ARMED;
                else if (bus.run)    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.halt) w_state_nxt = S_IDLE;
            end
            S_ARMED: begin
                if (bus.halt || w_rise) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_en  <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_core_en <= w_core_en_nxt;
            if (w_core_en_nxt) begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
        end
    end

    // Leaving or sitting in IDLE clears the watchdog so stalled is never seen there
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_stalled <= 1'b0;
        end else if (!w_active || w_state_nxt == S_IDLE || w_rise) begin
            r_wdog    <= '0;
            r_stalled <= 1'b0;
        end else begin
            if (r_wdog != c_wdog_max) begin
                r_wdog <= r_wdog + CNT_W'(1);
            end
            if (r_wdog == c_wdog_last) begin
                r_stalled <= 1'b1;
            end
        end
    end

    assign bus.core_en  = r_core_en;
    assign bus.tick_cnt = r_tick_cnt;
    assign bus.state    = r_state;
    assign bus.stalled  = r_stalled;

endmodule
`default_nettype wire

// File: tb/tb_clk_tick_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_tick_stepper
//  Purpose  : Directed and random stimulus for clk_tick_stepper against a
//             history-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_tick_stepper;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 5;
    localparam int TIMEOUT     = 20;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    clk_tick_stepper_if #(.CNT_W(CNT_W)) bus ();

    clk_tick_stepper #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: rise is read straight from the record of driven
    // clk_div_in values, SYNC_STAGES edges back.
    bit          hist[$];
    int unsigned m_state;
    bit          m_core;
    int unsigned m_tick;
    bit          m_stall;
    int          m_quiet;
    bit          m_step_prev;
    int          ph;

    function automatic bit peek_rise();
        return hist[hist.size()-SYNC_STAGES] && !hist[hist.size()-SYNC_STAGES-1];
    endfunction

    task automatic model_edge(input bit d, input bit i_run, input bit i_step,
                              input bit i_halt, input bit i_rst);
        bit          rise;
        bit          srise;
        bit          active;
        int unsigned nxt;
        if (i_rst) begin
            m_state = 0; m_core = 0; m_tick = 0; m_stall = 0;
            m_quiet = 0; m_step_prev = 0;
            repeat (SYNC_STAGES + 1) hist.push_back(1'b0);
        end else begin
            rise   = peek_rise();
            srise  = i_step && !m_step_prev;
            active = (m_state != 0);
            nxt    = m_state;
            if (i_halt)                           nxt = 0;
            else if (m_state == 0 && srise)       nxt = 2;
            else if (m_state == 0 && i_run)       nxt = 1;
            else if (m_state == 2 && rise)        nxt = 0;
            m_core = rise && !i_halt && active;
            if (m_core) m_tick = (m_tick + 1) % (1 << CNT_W);
            if (!active || nxt == 0 || rise) begin
                m_quiet = 0;
                m_stall = 0;
            end else begin
                m_quiet++;
                if (m_quiet >= TIMEOUT) m_stall = 1;
            end
            m_state     = nxt;
            m_step_prev = i_step;
            hist.push_back(d);
        end
        while (hist.size() > 16) void'(hist.pop_front());
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit d, input bit i_run, input bit i_step,
                       input bit i_halt, input bit i_rst);
        bus.clk_div_in = d;
        bus.run        = i_run;
        bus.step       = i_step;
        bus.halt       = i_halt;
        rst            = i_rst;
        model_edge(d, i_run, i_step, i_halt, i_rst);
        @(posedge clk);
        #1;
        check("core_en",  32'(bus.core_en),  32'(m_core));
        check("tick_cnt", 32'(bus.tick_cnt), m_tick);
        check("state",    32'(bus.state),    m_state);
        check("stalled",  32'(bus.stalled),  32'(m_stall));
    endtask

    // Slow clock toggling every 8 clk
    task automatic slow(input int n, input bit i_run);
        for (int i = 0; i < n; i++) begin
            cyc(ph[3], i_run, 1'b0, 1'b0, 1'b0);
            ph++;
        end
    endtask

    initial begin
        bit found;
        bit rd;
        checks = 0;
        errors = 0;
        ph     = 0;
        repeat (SYNC_STAGES + 1) hist.push_back(1'b0);
        m_state = 0; m_core = 0; m_tick = 0; m_stall = 0; m_quiet = 0; m_step_prev = 0;
        bus.clk_div_in = 1'b0; bus.run = 1'b0; bus.step = 1'b0; bus.halt = 1'b0; rst = 1'b1;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Free run: one strobe per slow rising edge, count climbs and wraps
        slow(600, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        slow(20, 1'b0);

        // Single step from IDLE: one strobe then back to IDLE
        cyc(ph[3], 1'b0, 1'b1, 1'b0, 1'b0);
        ph++;
        slow(40, 1'b0);

        // Halt coincident with a rise drops the strobe
        slow(12, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (peek_rise()) begin
                cyc(ph[3], 1'b1, 1'b0, 1'b1, 1'b0);
                found = 1'b1;
            end else begin
                cyc(ph[3], 1'b1, 1'b0, 1'b0, 1'b0);
            end
            ph++;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL halt_rise_search: observed %0d expected %0d", found, 1);
        end
        slow(10, 1'b0);

        // Stall watchdog: clk_div_in held low while running
        ph = 0;
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        slow(30, 1'b1);

        // Reset mid-run with the synchroniser full of ones
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ph = 8;
        slow(30, 1'b0);
        slow(40, 1'b1);

        // Random mix of all controls
        rd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) rd = ~rd;
            cyc(rd,
                ($urandom_range(3) != 0),
                ($urandom_range(9) == 0),
                ($urandom_range(39) == 0),
                ($urandom_range(499) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
